// File: rtl/sd_ctrl_pkg.sv
// Shared encodings for the SD sequencing layer: FSM states, CS/DIN path codes
// and a width helper.
package sd_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd1,
    ST_IDLE   = 4'd2,
    ST_RD     = 4'd3,
    ST_WR     = 4'd4,
    ST_DONE   = 4'd5,
    ST_RETRY  = 4'd6,
    ST_REINIT = 4'd7,
    ST_FATAL  = 4'd8
  } state_t;

  localparam logic [1:0] PATH_INIT = 2'b00;
  localparam logic [1:0] PATH_RD   = 2'b10;
  localparam logic [1:0] PATH_WR   = 2'b11;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sd_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, with
// wrap. The pointer register lives in the parent.
module sd_rr_arbiter
  import sd_ctrl_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int GW   = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [GW-1:0]   rr_ptr,
  output logic [GW-1:0]   grant,
  output logic            valid
);

  logic [GW-1:0] idx;
  int            pos;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    // Walk from the farthest offset down so the nearest requester is the last write.
    for (int i = N_CH - 1; i >= 0; i--) begin
      pos = int'(rr_ptr) + i;
      if (pos >= N_CH) pos = pos - N_CH;
      idx = GW'(pos);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_multi_ctrl.sv
// Multi-channel SD (SPI-mode) sequencer: arbitrates client channels onto the
// shared init/read/write engines with retry, timeout and a sticky fatal state.
module sd_multi_ctrl
  import sd_ctrl_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 4096,
  parameter int ADDR_W      = 32,
  parameter int DIV_LOG2    = 10,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3,
  localparam int GW = clog2_min1(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_we,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata,
  output logic [N_CH-1:0]          ch_done,
  output logic [N_CH-1:0]          ch_err,
  input  logic                     eng_init_ok,
  input  logic                     eng_init_err,
  input  logic                     eng_rd_ok,
  input  logic                     eng_rd_err,
  input  logic                     eng_wr_ok,
  input  logic                     eng_wr_err,
  output logic                     eng_rd_start,
  output logic                     eng_wr_start,
  output logic                     eng_rst,
  output logic [ADDR_W-1:0]        eng_addr,
  output logic [DATA_W-1:0]        eng_wdata,
  output logic                     clk_slow,
  output logic                     sd_clk_sel,
  output logic [1:0]               path_sel,
  output logic [GW-1:0]            grant,
  output logic                     busy,
  output logic                     fatal,
  output logic [3:0]               state
);

  localparam int TW = clog2_min1(TIMEOUT_CYC + 1);
  localparam int CW = clog2_min1(MAX_RETRY + 1);

  state_t              st;
  logic [TW-1:0]       phase_tmr;
  logic [CW-1:0]       init_tries;
  logic [CW-1:0]       retry_cnt;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       rr_ptr;
  logic                we_q;
  logic                err_flag;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DIV_LOG2-1:0] div_cnt;
  logic [GW-1:0]       arb_grant;
  logic                arb_valid;
  logic                timeout;
  logic                op_ok;
  logic                op_err;
  logic                retry_pulse;

  sd_rr_arbiter #(.N_CH(N_CH), .GW(GW)) u_arb (
    .req    (ch_req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  assign timeout = (phase_tmr == TW'(TIMEOUT_CYC - 1));
  // Only the engine matching the latched direction is listened to; ok beats err.
  assign op_ok   = we_q ? eng_wr_ok  : eng_rd_ok;
  assign op_err  = we_q ? eng_wr_err : eng_rd_err;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ST_INIT;
      phase_tmr  <= '0;
      init_tries <= '0;
      retry_cnt  <= '0;
      grant_q    <= '0;
      rr_ptr     <= '0;
      we_q       <= 1'b0;
      err_flag   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      // Timer free-runs; every state change below restarts it.
      phase_tmr <= phase_tmr + 1'b1;
      unique case (st)
        ST_INIT: begin
          if (eng_init_ok) begin
            st        <= ST_IDLE;
            phase_tmr <= '0;
          end else if (eng_init_err || timeout) begin
            st        <= (init_tries < CW'(MAX_RETRY)) ? ST_REINIT : ST_FATAL;
            phase_tmr <= '0;
          end
        end
        ST_REINIT: begin
          init_tries <= init_tries + 1'b1;
          st         <= ST_INIT;
          phase_tmr  <= '0;
        end
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q   <= arb_grant;
            we_q      <= ch_we[arb_grant];
            addr_q    <= ch_addr[int'(arb_grant)*ADDR_W +: ADDR_W];
            wdata_q   <= ch_wdata[int'(arb_grant)*DATA_W +: DATA_W];
            rr_ptr    <= (arb_grant == GW'(N_CH - 1)) ? '0 : arb_grant + 1'b1;
            retry_cnt <= '0;
            st        <= ch_we[arb_grant] ? ST_WR : ST_RD;
            phase_tmr <= '0;
          end
        end
        ST_RD, ST_WR: begin
          if (op_ok) begin
            err_flag  <= 1'b0;
            st        <= ST_DONE;
            phase_tmr <= '0;
          end else if (op_err || timeout) begin
            if (retry_cnt < CW'(MAX_RETRY)) begin
              st <= ST_RETRY;
            end else begin
              err_flag <= 1'b1;
              st       <= ST_DONE;
            end
            phase_tmr <= '0;
          end
        end
        ST_RETRY: begin
          retry_cnt <= retry_cnt + 1'b1;
          st        <= we_q ? ST_WR : ST_RD;
          phase_tmr <= '0;
        end
        ST_DONE: begin
          if (!ch_req[grant_q]) begin
            st        <= ST_IDLE;
            phase_tmr <= '0;
          end
        end
        ST_FATAL: st <= ST_FATAL;
        default: begin
          st        <= ST_INIT;
          phase_tmr <= '0;
        end
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    eng_rd_start = 1'b0;
    eng_wr_start = 1'b0;
    path_sel     = PATH_INIT;
    sd_clk_sel   = 1'b1;
    ch_done      = '0;
    ch_err       = '0;
    fatal        = 1'b0;
    retry_pulse  = 1'b0;
    unique case (st)
      ST_INIT:   sd_clk_sel = 1'b0;
      ST_REINIT: begin
        sd_clk_sel  = 1'b0;
        retry_pulse = 1'b1;
      end
      ST_FATAL: begin
        sd_clk_sel = 1'b0;
        fatal      = 1'b1;
        ch_err     = ch_req;
      end
      ST_RD, ST_WR, ST_DONE: begin
        path_sel     = we_q ? PATH_WR : PATH_RD;
        eng_rd_start = !we_q;
        eng_wr_start = we_q;
        if (st == ST_DONE) begin
          ch_done[grant_q] = !err_flag;
          ch_err[grant_q]  = err_flag;
        end
      end
      ST_RETRY: begin
        path_sel    = we_q ? PATH_WR : PATH_RD;
        retry_pulse = 1'b1;
      end
      default: ;
    endcase
  end

  assign eng_rst   = reset | retry_pulse;
  assign eng_addr  = addr_q;
  assign eng_wdata = wdata_q;
  assign clk_slow  = div_cnt[DIV_LOG2-1];
  assign grant     = grant_q;
  assign busy      = (st != ST_IDLE);
  assign state     = st;

endmodule

// File: tb/tb_sd_multi_ctrl.sv
// Directed bench for sd_multi_ctrl: init, read, fairness, retry, timeout,
// reset mid-write and init failure into the fatal state.
module tb_sd_multi_ctrl;

  localparam int N_CH = 2;
  localparam int DW   = 32;
  localparam int AW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   ch_req;
  logic [N_CH-1:0]   ch_we;
  logic [N_CH*AW-1:0] ch_addr;
  logic [N_CH*DW-1:0] ch_wdata;
  logic [N_CH-1:0]   ch_done;
  logic [N_CH-1:0]   ch_err;
  logic eng_init_ok, eng_init_err, eng_rd_ok, eng_rd_err, eng_wr_ok, eng_wr_err;
  logic eng_rd_start, eng_wr_start, eng_rst;
  logic [AW-1:0]     eng_addr;
  logic [DW-1:0]     eng_wdata;
  logic              clk_slow, sd_clk_sel, busy, fatal;
  logic [1:0]        path_sel;
  logic [0:0]        grant;
  logic [3:0]        state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sd_multi_ctrl #(
    .N_CH(N_CH), .DATA_W(DW), .ADDR_W(AW), .DIV_LOG2(4),
    .TIMEOUT_CYC(100), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_done(ch_done), .ch_err(ch_err),
    .eng_init_ok(eng_init_ok), .eng_init_err(eng_init_err),
    .eng_rd_ok(eng_rd_ok), .eng_rd_err(eng_rd_err),
    .eng_wr_ok(eng_wr_ok), .eng_wr_err(eng_wr_err),
    .eng_rd_start(eng_rd_start), .eng_wr_start(eng_wr_start), .eng_rst(eng_rst),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata), .clk_slow(clk_slow),
    .sd_clk_sel(sd_clk_sel), .path_sel(path_sel), .grant(grant),
    .busy(busy), .fatal(fatal), .state(state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [3:0] S_INIT = 4'd1, S_IDLE = 4'd2, S_RD = 4'd3, S_WR = 4'd4,
                         S_DONE = 4'd5, S_RETRY = 4'd6, S_REINIT = 4'd7, S_FATAL = 4'd8;

  initial begin
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    reset = 1'b1;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    eng_init_ok = 0; eng_init_err = 0; eng_rd_ok = 0; eng_rd_err = 0;
    eng_wr_ok = 0; eng_wr_err = 0;
    tick(3);

    // Reset values
    check("rst_state", state, S_INIT);
    check("rst_eng_rst", eng_rst, 1);
    check("rst_busy", busy, 1);
    check("rst_path", path_sel, 2'b00);
    check("rst_clksel", sd_clk_sel, 0);
    check("rst_fatal", fatal, 0);
    check("rst_starts", {eng_rd_start, eng_wr_start}, 2'b00);
    check("rst_done_err", {ch_done, ch_err}, 4'b0000);
    check("rst_addr", eng_addr, 0);
    check("rst_clk_slow", clk_slow, 0);
    reset = 1'b0;
    #1 check("init_eng_rst_low", eng_rst, 0);

    // Slow clock: divider counts edges since reset release, MSB is bit 3
    tick(7);
    check("clk_slow_cnt7", clk_slow, 0);
    tick(1);
    check("clk_slow_cnt8", clk_slow, 1);

    // Init completes after 50 cycles
    tick(42);
    check("init_hold", state, S_INIT);
    eng_init_ok = 1; tick(); eng_init_ok = 0;
    check("init_idle", state, S_IDLE);
    check("init_clksel", sd_clk_sel, 1);
    check("init_path", path_sel, 2'b00);
    check("init_busy", busy, 0);

    // Read on channel 1
    ch_addr[AW +: AW] = 32'h1234; ch_we = 2'b00; ch_req = 2'b10;
    tick();
    check("rd_state", state, S_RD);
    check("rd_grant", grant, 1);
    check("rd_addr", eng_addr, 32'h1234);
    check("rd_path", path_sel, 2'b10);
    check("rd_start", {eng_rd_start, eng_wr_start}, 2'b10);
    eng_wr_ok = 1; tick(); eng_wr_ok = 0;
    check("rd_ignore_wr_ok", state, S_RD);
    eng_rd_ok = 1; tick(); eng_rd_ok = 0;
    check("rd_done_state", state, S_DONE);
    check("rd_done", ch_done, 2'b10);
    tick(2);
    check("rd_done_hold", ch_done, 2'b10);
    check("rd_done_path", path_sel, 2'b10);
    ch_req = 2'b00; tick();
    check("rd_back_idle", state, S_IDLE);
    check("rd_done_clear", ch_done, 2'b00);
    check("rd_start_drop", eng_rd_start, 0);

    // Fairness with both channels requesting
    ch_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fair_grant%0d", i), grant, exp_g[i]);
      eng_rd_ok = 1;
      if (i == 1) eng_rd_err = 1;
      tick();
      eng_rd_ok = 0; eng_rd_err = 0;
      check($sformatf("fair_done%0d", i), {ch_done, ch_err}, {2'(1 << exp_g[i]), 2'b00});
      ch_req[exp_g[i]] = 1'b0;
      tick();
      check($sformatf("fair_idle%0d", i), state, S_IDLE);
      ch_req = 2'b11;
    end
    ch_req = 2'b00;
    tick();

    // Write with two retries, then success
    ch_we = 2'b01; ch_addr[0 +: AW] = 32'hABCD; ch_wdata[0 +: DW] = 32'hDEADBEEF;
    ch_req = 2'b01;
    tick();
    check("wr_state", state, S_WR);
    check("wr_path", path_sel, 2'b11);
    check("wr_wdata", eng_wdata, 32'hDEADBEEF);
    check("wr_start", {eng_rd_start, eng_wr_start}, 2'b01);
    for (int i = 0; i < 2; i++) begin
      eng_wr_err = 1; tick(); eng_wr_err = 0;
      check($sformatf("wr_retry%0d", i), {state, eng_rst, eng_wr_start}, {S_RETRY, 2'b10});
      tick();
      check($sformatf("wr_reenter%0d", i), {state, eng_rst}, {S_WR, 1'b0});
    end
    eng_wr_ok = 1; tick(); eng_wr_ok = 0;
    check("wr_done", {ch_done, ch_err}, 4'b0100);
    ch_req = 2'b00; tick();

    // Write exhausting retries
    ch_req = 2'b01; tick();
    for (int i = 0; i < 3; i++) begin
      eng_wr_err = 1; tick(); eng_wr_err = 0;
      check($sformatf("wr4_retry%0d", i), state, S_RETRY);
      tick();
    end
    eng_wr_err = 1; tick(); eng_wr_err = 0;
    check("wr4_err", {state, ch_done, ch_err}, {S_DONE, 4'b0001});
    ch_req = 2'b00; tick();
    check("wr4_idle", state, S_IDLE);

    // Timeout: 100 silent cycles in WR, then RETRY
    ch_req = 2'b01; tick();
    check("to_wr", state, S_WR);
    tick(99);
    check("to_still_wr", state, S_WR);
    tick();
    check("to_retry", state, S_RETRY);
    tick();
    check("to_back_wr", state, S_WR);

    // Asynchronous reset in the middle of a write
    reset = 1'b1; #1;
    check("rst_mid_state", state, S_INIT);
    check("rst_mid_out", {eng_rd_start, eng_wr_start, eng_rst, path_sel}, 5'b00100);
    check("rst_mid_addr", eng_addr, 0);
    ch_req = 2'b00;
    tick();
    reset = 1'b0;
    #1;

    // Init failure: three REINIT pulses, then sticky FATAL
    for (int i = 0; i < 3; i++) begin
      eng_init_err = 1; tick(); eng_init_err = 0;
      check($sformatf("reinit%0d", i), {state, eng_rst}, {S_REINIT, 1'b1});
      tick();
      check($sformatf("reinit_back%0d", i), {state, eng_rst}, {S_INIT, 1'b0});
    end
    eng_init_err = 1; tick(); eng_init_err = 0;
    check("fatal_state", {state, fatal}, {S_FATAL, 1'b1});
    ch_req = 2'b01; #1;
    check("fatal_err", ch_err, 2'b01);
    eng_init_ok = 1; tick(5); eng_init_ok = 0;
    check("fatal_sticky", {state, fatal, ch_done}, {S_FATAL, 1'b1, 2'b00});
    ch_req = 2'b00; #1;
    check("fatal_err_clear", ch_err, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
